// File: rtl/vocab_pkg.sv
// Shared types and helpers for the vocabulary SRAM controller.
// Holds the FSM encoding, the null pointer and the word-width helper.
package vocab_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        SCAN  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic int word_width(input int wl, input int dw);
        return wl * dw;
    endfunction

    // All-ones address of the given width, used as the miss pointer.
    function automatic logic [31:0] null_ptr(input int aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

endpackage

// File: rtl/vocab_addr_cnt.sv
// Loadable up-counter used as the scan issue index.
// Latches start and end on load; done while the address has reached the end.
module vocab_addr_cnt
    import vocab_pkg::*;
#(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] start_i,
    input  logic [CW-1:0] end_i,
    input  logic          en_i,
    output logic [CW-1:0] addr_o,
    output logic          done_o
);

    logic [CW-1:0] addr_q;
    logic [CW-1:0] end_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            end_q  <= '0;
        end else if (load_i) begin
            addr_q <= start_i;
            end_q  <= end_i;
        end else if (en_i && !done_o) begin
            addr_q <= addr_q + CW'(1);
        end
    end

    assign addr_o = addr_q;
    assign done_o = (addr_q >= end_q);

endmodule

// File: rtl/vocab_ctrl.sv
// Vocabulary SRAM controller: arbitrates a word loader and a linear-scan
// query port over one single-port RAM, tracking fill level and overflow.
module vocab_ctrl
    import vocab_pkg::*;
#(
    parameter  int ADDR_WIDTH  = 4,
    parameter  int WORD_LENGTH = 3,
    parameter  int DATA_WIDTH  = 8,
    localparam int W           = word_width(WORD_LENGTH, DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [W-1:0]          a_word,
    input  logic                  q_valid,
    output logic                  q_ready,
    input  logic [W-1:0]          q_word,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic                  r_hit,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  overflow,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [W-1:0]          mem_din,
    input  logic [W-1:0]          mem_dout
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] NULLPTR =
        ADDR_WIDTH'(null_ptr(ADDR_WIDTH));
    localparam logic [CW-1:0] CAP = CW'(1) << ADDR_WIDTH;
    localparam logic [CW-1:0] ONE = CW'(1);

    state_t                state_q;
    logic [W-1:0]          word_q;
    logic [CW-1:0]         fill_q;
    logic [CW-1:0]         n_q;
    logic                  ovf_q;
    logic                  rvalid_q;
    logic                  rhit_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic                  cmp_vld_q;
    logic [CW-1:0]         cmp_idx_q;

    logic [CW-1:0] cnt_addr;
    logic          cnt_done;
    logic          cnt_en;
    logic          cnt_load;
    logic          full;
    logic          match;

    assign full     = (fill_q == CAP);
    assign cnt_en   = (state_q == SCAN) && !cnt_done;
    assign cnt_load = q_valid && q_ready;
    assign match    = cmp_vld_q && (mem_dout == word_q);

    vocab_addr_cnt #(
        .CW(CW)
    ) u_issue (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .start_i('0),
        .end_i  (fill_q),
        .en_i   (cnt_en),
        .addr_o (cnt_addr),
        .done_o (cnt_done)
    );

    assign a_ready = !rst && (state_q == IDLE);
    assign q_ready = a_ready && !a_valid;

    assign mem_we  = !rst && (state_q == WRITE) && !full;
    assign mem_en  = mem_we || (!rst && cnt_en);
    assign mem_din = mem_we ? word_q : '0;

    always_comb begin
        mem_addr = '0;
        if (mem_we) begin
            mem_addr = fill_q[ADDR_WIDTH-1:0];
        end else if (mem_en) begin
            mem_addr = cnt_addr[ADDR_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            word_q    <= '0;
            fill_q    <= '0;
            n_q       <= '0;
            ovf_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rhit_q    <= 1'b0;
            raddr_q   <= '0;
            cmp_vld_q <= 1'b0;
            cmp_idx_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (a_valid) begin
                        word_q  <= a_word;
                        state_q <= WRITE;
                    end else if (q_valid) begin
                        word_q    <= q_word;
                        n_q       <= fill_q;
                        cmp_vld_q <= 1'b0;
                        cmp_idx_q <= '0;
                        if (fill_q == '0) begin
                            rvalid_q <= 1'b1;
                            rhit_q   <= 1'b0;
                            raddr_q  <= NULLPTR;
                            state_q  <= RESP;
                        end else begin
                            state_q <= SCAN;
                        end
                    end
                end
                WRITE: begin
                    if (full) begin
                        ovf_q <= 1'b1;
                    end else begin
                        fill_q <= fill_q + ONE;
                    end
                    state_q <= IDLE;
                end
                SCAN: begin
                    // Compare stage trails the issue stage by the RAM latency.
                    cmp_vld_q <= cnt_en;
                    cmp_idx_q <= cnt_addr;
                    if (match) begin
                        rvalid_q <= 1'b1;
                        rhit_q   <= 1'b1;
                        raddr_q  <= cmp_idx_q[ADDR_WIDTH-1:0];
                        state_q  <= RESP;
                    end else if (cmp_vld_q && cmp_idx_q == n_q - ONE) begin
                        rvalid_q <= 1'b1;
                        rhit_q   <= 1'b0;
                        raddr_q  <= NULLPTR;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    if (r_ready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign r_valid    = rvalid_q;
    assign r_hit      = rhit_q;
    assign r_addr     = raddr_q;
    assign fill_count = fill_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_vocab_ctrl.sv
// Randomised self-checking bench for vocab_ctrl.
// Queue-based reference model plus documented cycle timing.
module tb_vocab_ctrl;

  localparam int AW  = 4;
  localparam int WL  = 3;
  localparam int DW  = 8;
  localparam int W   = WL * DW;
  localparam int CAP = 1 << AW;

  localparam logic [W-1:0] HEL = {8'h48, 8'h65, 8'h6C};
  localparam logic [W-1:0] LO  = {8'h6C, 8'h6F, 8'h20};
  localparam logic [W-1:0] ABC = {8'h61, 8'h62, 8'h63};
  localparam logic [W-1:0] XYZ = {8'h78, 8'h79, 8'h7A};
  localparam logic [W-1:0] NEW = {8'h6E, 8'h65, 8'h77};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [W-1:0]  a_word = '0;
  logic          q_valid = 1'b0;
  logic          q_ready;
  logic [W-1:0]  q_word = '0;
  logic          r_valid;
  logic          r_ready = 1'b0;
  logic          r_hit;
  logic [AW-1:0] r_addr;
  logic [AW:0]   fill_count;
  logic          overflow;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_din;
  logic [W-1:0]  mem_dout = '0;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] ram [CAP];
  logic [W-1:0] ref_q [$];
  bit           ref_ovf = 1'b0;

  vocab_ctrl #(
    .ADDR_WIDTH (AW),
    .WORD_LENGTH(WL),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_word    (a_word),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .q_word    (q_word),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_hit     (r_hit),
    .r_addr    (r_addr),
    .fill_count(fill_count),
    .overflow  (overflow),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else        mem_dout <= ram[mem_addr];
    end
  end

  function automatic int ref_find(input logic [W-1:0] w);
    for (int i = 0; i < ref_q.size(); i++)
      if (ref_q[i] == w) return i;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 1'b0;
    q_valid = 1'b0;
    r_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_q.delete();
    ref_ovf = 1'b0;
  endtask

  task automatic do_append(input logic [W-1:0] w);
    bit full;
    full = (ref_q.size() == CAP);
    a_valid = 1'b1;
    a_word  = w;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL append_ready got=%b exp=1", a_ready);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_en !== !full || mem_we !== !full) begin
      errors++;
      $display("FAIL append_write en=%b we=%b exp=%b",
               mem_en, mem_we, !full);
    end
    if (!full) begin
      checks++;
      if (mem_addr !== AW'(ref_q.size()) || mem_din !== w) begin
        errors++;
        $display("FAIL append_addr addr=%0d din=%h exp=%0d/%h",
                 mem_addr, mem_din, ref_q.size(), w);
      end
    end
    if (full) ref_ovf = 1'b1;
    else      ref_q.push_back(w);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (fill_count !== (AW+1)'(ref_q.size()) || overflow !== ref_ovf
        || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL append_fill fill=%0d ovf=%b rdy=%b exp=%0d/%b/1",
               fill_count, overflow, a_ready, ref_q.size(), ref_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_result(input logic [W-1:0] w, input int hold);
    int n, idx, exp_lat, exp_en, lat, en_cnt;
    bit exp_hit;
    logic [AW-1:0] exp_addr;
    n = ref_q.size();
    idx = ref_find(w);
    exp_hit = (idx >= 0);
    exp_addr = exp_hit ? AW'(idx) : '1;
    if (n == 0) begin
      exp_lat = 1; exp_en = 0;
    end else if (exp_hit) begin
      exp_lat = idx + 3;
      exp_en = (idx + 2 < n) ? idx + 2 : n;
    end else begin
      exp_lat = n + 2; exp_en = n;
    end
    lat = 0;
    en_cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (r_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (mem_en === 1'b1) en_cnt++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL query_latency got=%0d exp=%0d", lat, exp_lat);
    end
    checks++;
    if (r_hit !== exp_hit) begin
      errors++;
      $display("FAIL query_hit got=%b exp=%b", r_hit, exp_hit);
    end
    checks++;
    if (r_addr !== exp_addr) begin
      errors++;
      $display("FAIL query_addr got=%h exp=%h", r_addr, exp_addr);
    end
    checks++;
    if (en_cnt != exp_en) begin
      errors++;
      $display("FAIL query_reads got=%0d exp=%0d", en_cnt, exp_en);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (r_valid !== 1'b1 || r_hit !== exp_hit
          || r_addr !== exp_addr) begin
        errors++;
        $display("FAIL resp_hold v=%b hit=%b addr=%h exp=1/%b/%h",
                 r_valid, r_hit, r_addr, exp_hit, exp_addr);
      end
    end
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (r_valid !== 1'b0) begin
      errors++;
      $display("FAIL resp_release got=%b exp=0", r_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_query(input logic [W-1:0] w, input int hold);
    q_valid = 1'b1;
    q_word  = w;
    @(negedge clk);
    checks++;
    if (q_ready !== 1'b1) begin
      errors++;
      $display("FAIL query_ready got=%b exp=1", q_ready);
    end
    @(posedge clk); #1;
    q_valid = 1'b0;
    wait_result(w, hold);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1'b1;
    q_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0 || q_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready a=%b q=%b exp=0/0", a_ready, q_ready);
    end
    checks++;
    if (fill_count !== '0 || overflow !== 1'b0 || r_valid !== 1'b0
        || r_hit !== 1'b0 || r_addr !== '0) begin
      errors++;
      $display("FAIL reset_regs fill=%0d ovf=%b v=%b hit=%b addr=%h",
               fill_count, overflow, r_valid, r_hit, r_addr);
    end
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0
        || mem_din !== '0) begin
      errors++;
      $display("FAIL reset_mem en=%b we=%b addr=%h din=%h exp=0",
               mem_en, mem_we, mem_addr, mem_din);
    end
    a_valid = 1'b0;
    q_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || q_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready a=%b q=%b exp=1/1", a_ready, q_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_empty_query();
    do_query(XYZ, 0);
  endtask

  task automatic test_load_query();
    do_append(HEL);
    do_append(LO);
    do_append(ABC);
    do_query(LO, 0);
  endtask

  task automatic test_miss();
    do_query(XYZ, 0);
  endtask

  task automatic test_duplicate();
    do_reset();
    do_append(HEL);
    do_append(LO);
    do_append(HEL);
    do_query(HEL, 0);
  endtask

  task automatic test_simultaneous();
    int waited;
    a_valid = 1'b1;
    a_word  = NEW;
    q_valid = 1'b1;
    q_word  = NEW;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || q_ready !== 1'b0) begin
      errors++;
      $display("FAIL arb_priority a=%b q=%b exp=1/0", a_ready, q_ready);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    ref_q.push_back(NEW);
    waited = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (q_ready === 1'b1) begin
        waited = k;
        break;
      end
    end
    checks++;
    if (waited != 2) begin
      errors++;
      $display("FAIL arb_query_wait got=%0d exp=2", waited);
    end
    @(posedge clk); #1;
    q_valid = 1'b0;
    wait_result(NEW, 0);
  endtask

  task automatic test_overflow();
    logic [W-1:0] last;
    do_reset();
    last = '0;
    for (int i = 0; i < CAP; i++) begin
      last = {8'h80 | 8'(i), 16'($urandom)};
      do_append(last);
    end
    do_append(XYZ);
    do_query(last, 0);
  endtask

  task automatic test_reset_scan();
    do_reset();
    do_append(HEL);
    do_append(LO);
    do_append(ABC);
    do_append(NEW);
    q_valid = 1'b1;
    q_word  = XYZ;
    @(negedge clk);
    @(posedge clk); #1;
    q_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0) begin
      errors++;
      $display("FAIL scan_rst_ready got=%b exp=0", a_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ref_q.delete();
    ref_ovf = 1'b0;
    @(negedge clk);
    checks++;
    if (r_valid !== 1'b0 || fill_count !== '0 || a_ready !== 1'b1
        || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL scan_rst_state v=%b fill=%0d rdy=%b en=%b",
               r_valid, fill_count, a_ready, mem_en);
    end
    @(posedge clk); #1;
    do_query(HEL, 0);
  endtask

  task automatic test_hold();
    do_reset();
    do_append(HEL);
    do_append(LO);
    do_query(LO, 5);
  endtask

  task automatic test_random();
    logic [W-1:0] pool [5];
    do_reset();
    for (int i = 0; i < 5; i++) pool[i] = W'($urandom);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0)
        do_append(pool[$urandom_range(0, 4)]);
      else if ($urandom_range(0, 3) == 0)
        do_query(W'($urandom), $urandom_range(0, 2));
      else
        do_query(pool[$urandom_range(0, 4)], $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_empty_query();
    test_load_query();
    test_miss();
    test_duplicate();
    test_simultaneous();
    test_overflow();
    test_reset_scan();
    test_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
